// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with pixel-fetch lead.
//
// A single raster counter (h_cnt_r, v_cnt_r) sweeps the frame. Pixel requests
// are decoded straight from that counter. Sync, enable and frame-start are
// decoded from the same position, then delayed by REQ_LEAD pipeline stages.
// This makes every request lead its displayed pixel by exactly REQ_LEAD
// cycles. The pipeline resets to idle values, so the display side stays quiet
// until the first (0,0).
//
// Ports:
//   clk         in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   pattern_en  in   1 = colour bars, 0 = pix_data (sampled on frame_start)
//   pix_data    in   RGB565 for a requested pixel, REQ_LEAD-1 cycles after pix_req
//   pix_req     out  pixel fetch request
//   pix_x/pix_y out  requested column/row (0 when pix_req = 0)
//   hsync/vsync out  sync pulses with configurable polarity
//   vga_de      out  visible-pixel enable
//   vga_rgb     out  RGB565 pixel (0 outside the visible area)
//   frame_start out  one-cycle pulse at display position (0,0)
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int REQ_LEAD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pattern_en,
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST      = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [11:0] V_LAST      = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic        HS_ON       = 1'(HS_POL);
  localparam logic        VS_ON       = 1'(VS_POL);
  localparam int          LAST        = REQ_LEAD - 1;

  // Colour-bar lookup: eight equal-width bars across the active line.
  function automatic logic [15:0] bar_colour(input logic [10:0] x);
    logic [13:0] scaled;
    logic [2:0]  idx;
    scaled = {x, 3'b000};
    idx    = 3'(scaled / 14'(H_ACTIVE));
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  logic [11:0] h_cnt_r;
  logic [11:0] v_cnt_r;

  logic        h_act_s;
  logic        v_act_s;
  logic        req_s;
  logic [10:0] x_s;
  logic [10:0] y_s;
  logic        hs_s;
  logic        vs_s;
  logic        fs_s;
  logic [15:0] col_s;

  logic [REQ_LEAD-1:0] de_pipe_r;
  logic [REQ_LEAD-1:0] hs_pipe_r;
  logic [REQ_LEAD-1:0] vs_pipe_r;
  logic [REQ_LEAD-1:0] fs_pipe_r;
  logic [15:0]         col_pipe_r [REQ_LEAD];

  logic        pix_req_r;
  logic [10:0] pix_x_r;
  logic [10:0] pix_y_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        vga_de_r;
  logic [15:0] vga_rgb_r;
  logic        frame_start_r;
  logic        mode_r;

  // Raster position counter; v advances when h wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 12'd0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= 12'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 12'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 12'd1;
    end
  end

  // Decode the current raster position into request, sync and colour terms.
  always_comb begin
    h_act_s = (h_cnt_r >= H_ACT_START) && (h_cnt_r < H_ACT_END);
    v_act_s = (v_cnt_r >= V_ACT_START) && (v_cnt_r < V_ACT_END);
    req_s   = h_act_s && v_act_s;
    x_s     = 11'(h_cnt_r - H_ACT_START);
    y_s     = 11'(v_cnt_r - V_ACT_START);
    hs_s    = (h_cnt_r < H_SYNC_END) ? HS_ON : ~HS_ON;
    vs_s    = (v_cnt_r < V_SYNC_END) ? VS_ON : ~VS_ON;
    fs_s    = (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
    col_s   = bar_colour(x_s);
  end

  // Request outputs; coordinates are forced to zero between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req_r <= 1'b0;
      pix_x_r   <= 11'd0;
      pix_y_r   <= 11'd0;
    end else if (req_s) begin
      pix_req_r <= 1'b1;
      pix_x_r   <= x_s;
      pix_y_r   <= y_s;
    end else begin
      pix_req_r <= 1'b0;
      pix_x_r   <= 11'd0;
      pix_y_r   <= 11'd0;
    end
  end

  // Delay display-side terms by REQ_LEAD stages; idle values fill it at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe_r <= '0;
      hs_pipe_r <= {REQ_LEAD{~HS_ON}};
      vs_pipe_r <= {REQ_LEAD{~VS_ON}};
      fs_pipe_r <= '0;
      for (int i = 0; i < REQ_LEAD; i++) begin
        col_pipe_r[i] <= 16'h0000;
      end
    end else begin
      de_pipe_r[0]  <= req_s;
      hs_pipe_r[0]  <= hs_s;
      vs_pipe_r[0]  <= vs_s;
      fs_pipe_r[0]  <= fs_s;
      col_pipe_r[0] <= col_s;
      for (int i = 1; i < REQ_LEAD; i++) begin
        de_pipe_r[i]  <= de_pipe_r[i-1];
        hs_pipe_r[i]  <= hs_pipe_r[i-1];
        vs_pipe_r[i]  <= vs_pipe_r[i-1];
        fs_pipe_r[i]  <= fs_pipe_r[i-1];
        col_pipe_r[i] <= col_pipe_r[i-1];
      end
    end
  end

  // Display outputs. pix_data is captured at the same edge its pixel goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r       <= ~HS_ON;
      vsync_r       <= ~VS_ON;
      vga_de_r      <= 1'b0;
      frame_start_r <= 1'b0;
      vga_rgb_r     <= 16'h0000;
    end else begin
      hsync_r       <= hs_pipe_r[LAST];
      vsync_r       <= vs_pipe_r[LAST];
      vga_de_r      <= de_pipe_r[LAST];
      frame_start_r <= fs_pipe_r[LAST];
      if (!de_pipe_r[LAST]) begin
        vga_rgb_r <= 16'h0000;
      end else if (mode_r) begin
        vga_rgb_r <= col_pipe_r[LAST];
      end else begin
        vga_rgb_r <= pix_data;
      end
    end
  end

  // Latch the source mode on the frame_start cycle; (0,0) lies in sync, so
  // the new mode covers every visible pixel of that frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
    end else if (frame_start_r) begin
      mode_r <= pattern_en;
    end else begin
      mode_r <= mode_r;
    end
  end

  assign pix_req     = pix_req_r;
  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign vga_de      = vga_de_r;
  assign vga_rgb     = vga_rgb_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a small raster (H 2/2/4/2, V 1/1/3/1,
// REQ_LEAD 2). One instance uses active-low syncs and a second uses active-high
// syncs. The second instance must match the first except for inverted syncs.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pattern_en;
  logic [15:0] pix_data;

  logic        pix_req, hsync, vsync, vga_de, frame_start;
  logic [10:0] pix_x, pix_y;
  logic [15:0] vga_rgb;
  logic        pix_req1, hsync1, vsync1, vga_de1, frame_start1;
  logic [10:0] pix_x1, pix_y1;
  logic [15:0] vga_rgb1;

  int checks   = 0;
  int failures = 0;
  int n;
  int tb_mode;
  int de_seen  = 0;
  int fs_seen  = 0;
  int fs_first = -1;
  logic [15:0] rgb_32 = 16'h0;
  logic [15:0] held;
  logic [15:0] bar_tab [4] = '{16'hFFFF, 16'h07FF, 16'hF81F, 16'h001F};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .HS_POL(0), .VS_POL(0), .REQ_LEAD(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pattern_en(pattern_en), .pix_data(pix_data),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync),
    .vsync(vsync), .vga_de(vga_de), .vga_rgb(vga_rgb), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .HS_POL(1), .VS_POL(1), .REQ_LEAD(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pattern_en(pattern_en), .pix_data(pix_data),
    .pix_req(pix_req1), .pix_x(pix_x1), .pix_y(pix_y1), .hsync(hsync1),
    .vsync(vsync1), .vga_de(vga_de1), .vga_rgb(vga_rgb1), .frame_start(frame_start1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp_v);
    end
  endtask

  // Every output of both instances at its reset value.
  task automatic check_idle(input string tag);
    check_val({tag, "_hs0"},  32'(hsync), 32'd1);
    check_val({tag, "_vs0"},  32'(vsync), 32'd1);
    check_val({tag, "_hs1"},  32'(hsync1), 32'd0);
    check_val({tag, "_vs1"},  32'(vsync1), 32'd0);
    check_val({tag, "_de"},   32'({vga_de, vga_de1}), 32'd0);
    check_val({tag, "_req"},  32'({pix_req, pix_req1}), 32'd0);
    check_val({tag, "_fs"},   32'({frame_start, frame_start1}), 32'd0);
    check_val({tag, "_xy"},   {pix_x[7:0], pix_y[7:0], pix_x1[7:0], pix_y1[7:0]}, 32'd0);
    check_val({tag, "_rgb"},  {vga_rgb, vga_rgb1}, 32'd0);
  endtask

  // Compare cycle n (counted from reset release) against the hand-derived raster.
  task automatic check_cycle();
    int d, e, h, v, eh, ev;
    logic exp_hs, exp_vs, exp_de, exp_fs, exp_req;
    logic [10:0] exp_x, exp_y;
    logic [15:0] exp_rgb;
    d = n - 3;
    h = (d >= 0) ? d % 10 : 0;
    v = (d >= 0) ? (d / 10) % 6 : 0;
    exp_hs = (d >= 0 && h < 2) ? 1'b0 : 1'b1;
    exp_vs = (d >= 0 && v < 1) ? 1'b0 : 1'b1;
    exp_de = (d >= 0 && h >= 4 && h < 8 && v >= 2 && v < 5);
    exp_fs = (d >= 0 && d % 60 == 0);
    e  = n - 1;
    eh = (e >= 0) ? e % 10 : 0;
    ev = (e >= 0) ? (e / 10) % 6 : 0;
    exp_req = (e >= 0 && eh >= 4 && eh < 8 && ev >= 2 && ev < 5);
    exp_x = exp_req ? 11'(eh - 4) : 11'd0;
    exp_y = exp_req ? 11'(ev - 2) : 11'd0;
    if (!exp_de)           exp_rgb = 16'h0000;
    else if (tb_mode != 0) exp_rgb = bar_tab[h-4];
    else                   exp_rgb = {5'(v - 2), 11'(h - 4)};

    check_val("hsync",  32'(hsync),  32'(exp_hs));
    check_val("vsync",  32'(vsync),  32'(exp_vs));
    check_val("de",     32'(vga_de), 32'(exp_de));
    check_val("fstart", 32'(frame_start), 32'(exp_fs));
    check_val("req",    32'(pix_req), 32'(exp_req));
    check_val("pix_xy", {5'd0, pix_x, 5'd0, pix_y}, {5'd0, exp_x, 5'd0, exp_y});
    check_val("rgb",    32'(vga_rgb), 32'(exp_rgb));
    check_val("pol1_sync", 32'({hsync1, vsync1}), 32'({~exp_hs, ~exp_vs}));
    check_val("pol1_rest", {vga_rgb1, 5'd0, vga_de1, frame_start1, pix_req1, 5'd0, pix_x1[2:0]},
              {exp_rgb, 5'd0, exp_de, exp_fs, exp_req, 5'd0, exp_x[2:0]});

    if (n >= 3 && n < 63 && vga_de) de_seen++;
    if (frame_start) begin
      fs_seen++;
      if (fs_first < 0) fs_first = n;
    end
    if (d >= 0 && d < 60 && h == 7 && v == 4) rgb_32 = vga_rgb;
    if (exp_fs) tb_mode = pattern_en ? 1 : 0;
  endtask

  // Step cycles; pix_data returns {y[4:0], x} of the previous cycle's request.
  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      check_cycle();
      pix_data = held;
      held     = {pix_y[4:0], pix_x};
      @(posedge clk);
      #2;
      n++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pattern_en = 1'b0;
    pix_data   = 16'h0000;
    held       = 16'h0000;
    n          = 0;
    tb_mode    = 0;
    repeat (2) @(posedge clk);
    #2;
    check_idle("reset");

    rst_n = 1'b1;
    run(33);
    pattern_en = 1'b1;
    run(92);
    check_val("de_per_frame", 32'(de_seen), 32'd12);
    check_val("rgb_x3_y2", 32'(rgb_32), 32'h1003);
    check_val("fs_count", 32'(fs_seen), 32'd3);

    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    repeat (3) @(posedge clk);
    #2;
    check_idle("rst_hold");

    rst_n    = 1'b1;
    n        = 0;
    tb_mode  = 0;
    held     = 16'h0000;
    pix_data = 16'h0000;
    fs_first = -1;
    run(70);
    check_val("fs_after_rst", 32'(fs_first), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
